// File: rtl/fb_swap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_swap_pkg : buffer state type and lowest-index search helper       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fb_swap_pkg;

   typedef enum logic [1:0] {
      BUF_FREE    = 2'd0,
      BUF_DRAWING = 2'd1,
      BUF_READY   = 2'd2,
      BUF_SHOWING = 2'd3
   } buf_state_t;

   localparam int MAX_BUFS = 4;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   // Walk downwards so the lowest set bit is the one that sticks.
   function automatic pick_t lowest_match(input logic [MAX_BUFS-1:0] hits);
      pick_t r;
      r = '0;
      for (int i = MAX_BUFS - 1; i >= 0; i--) begin
         if (hits[i]) begin
            r.found = 1'b1;
            r.idx   = 2'(i);
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fb_swap_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_swap_pick : combinational lowest-index finder for a buffer state  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fb_swap_pick
   import fb_swap_pkg::*;
#(
   parameter  int NUM_BUFS = 3,
   localparam int IDX_W    = $clog2(NUM_BUFS)
)(
   input  buf_state_t [NUM_BUFS-1:0] states,
   input  buf_state_t                target,
   output logic                      found,
   output logic [IDX_W-1:0]          idx
);

   logic [MAX_BUFS-1:0] hits;
   pick_t               result;

   for (genvar i = 0; i < MAX_BUFS; i++) begin : g_hit
      if (i < NUM_BUFS) begin : g_live
         assign hits[i] = (states[i] == target);
      end else begin : g_pad
         assign hits[i] = 1'b0;
      end
   end

   assign result = lowest_match(hits);
   assign found  = result.found;
   assign idx    = result.idx[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_swap_ctrl : N-way framebuffer ownership / swap controller         |
// | Optional counters: define FB_SWAP_STATS_EN.   Rev 1.0                |
// +----------------------------------------------------------------------+
module fb_swap_ctrl
   import fb_swap_pkg::*;
#(
   parameter  int                    NUM_BUFS   = 3,
   parameter  int                    ADDR_WIDTH = 20,
   parameter  logic [ADDR_WIDTH-1:0] BUF_STRIDE = 20'h20000,
   localparam int                    IDX_W      = $clog2(NUM_BUFS)
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_req,
   output logic                  wr_grant,
   output logic                  wr_busy,
   output logic [IDX_W-1:0]      wr_buf,
   output logic [ADDR_WIDTH-1:0] wr_base,
   input  logic                  wr_done,
   input  logic                  frame_start,
   output logic [IDX_W-1:0]      disp_buf,
   output logic [ADDR_WIDTH-1:0] disp_base,
   output logic                  swapped
`ifdef FB_SWAP_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [15:0]           stat_dropped,
   output logic [15:0]           stat_repeats
`endif
);

   buf_state_t [NUM_BUFS-1:0] st;
   buf_state_t [NUM_BUFS-1:0] st_nxt;

   logic             free_found, ready_found, show_found;
   logic [IDX_W-1:0] free_idx, ready_idx, show_idx;
   logic             done_fire, grant_fire, have_ready, swap_fire;
   logic [IDX_W-1:0] present_idx;

   function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [IDX_W-1:0] i);
      return ADDR_WIDTH'(i) * BUF_STRIDE;
   endfunction

   fb_swap_pick #(.NUM_BUFS(NUM_BUFS)) u_pick_free (
      .states (st), .target (BUF_FREE),    .found (free_found),  .idx (free_idx)
   );
   fb_swap_pick #(.NUM_BUFS(NUM_BUFS)) u_pick_ready (
      .states (st), .target (BUF_READY),   .found (ready_found), .idx (ready_idx)
   );
   fb_swap_pick #(.NUM_BUFS(NUM_BUFS)) u_pick_show (
      .states (st), .target (BUF_SHOWING), .found (show_found),  .idx (show_idx)
   );

   // Grant looks only at registered state, so a buffer freed by this
   // cycle's swap becomes grantable one cycle later.
   assign done_fire   = wr_done && wr_busy;
   assign grant_fire  = wr_req && !wr_busy && free_found;
   assign have_ready  = done_fire || ready_found;
   assign present_idx = done_fire ? wr_buf : ready_idx;
   assign swap_fire   = frame_start && have_ready;

   // Done resolves before present so a frame finished this cycle is shown now.
   always_comb begin
      st_nxt = st;
      if (done_fire) begin
         if (ready_found) begin
            st_nxt[ready_idx] = BUF_FREE;
         end
         st_nxt[wr_buf] = BUF_READY;
      end
      if (swap_fire) begin
         if (show_found) begin
            st_nxt[show_idx] = BUF_FREE;
         end
         st_nxt[present_idx] = BUF_SHOWING;
      end
      if (grant_fire) begin
         st_nxt[free_idx] = BUF_DRAWING;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            st[i] <= (i == 0) ? BUF_SHOWING : BUF_FREE;
         end
         wr_grant  <= 1'b0;
         wr_busy   <= 1'b0;
         wr_buf    <= '0;
         wr_base   <= '0;
         disp_buf  <= '0;
         disp_base <= '0;
         swapped   <= 1'b0;
      end else begin
         st       <= st_nxt;
         wr_grant <= grant_fire;
         swapped  <= swap_fire;
         if (grant_fire) begin
            wr_busy <= 1'b1;
            wr_buf  <= free_idx;
            wr_base <= base_of(free_idx);
         end else if (done_fire) begin
            wr_busy <= 1'b0;
         end
         if (swap_fire) begin
            disp_buf  <= present_idx;
            disp_base <= base_of(present_idx);
         end
      end
   end

`ifdef FB_SWAP_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_dropped <= '0;
         stat_repeats <= '0;
      end else if (stat_clr) begin
         stat_dropped <= '0;
         stat_repeats <= '0;
      end else begin
         if (done_fire && ready_found && (stat_dropped != 16'hFFFF)) begin
            stat_dropped <= stat_dropped + 16'd1;
         end
         if (frame_start && !have_ready && (stat_repeats != 16'hFFFF)) begin
            stat_repeats <= stat_repeats + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire
